// File: rtl/trap_sequencer_if.sv
// Supervisor trap hookup bundle between the trap sequencer and its neighbours
// (decode/execute requesters, CSR file, fetch redirect, pipeline drain).
//
// Modports:
//   master - the trap sequencer. It consumes requests and CSR state, and drives
//            readies, flush, commit strobes, trap values and the fetch redirect.
//   slave  - the surrounding core or testbench.
//
// Signal groups:
//   request  : cur_priv, exc_*, sret_*, irq_pc
//   csr in   : csr_sstatus_q, csr_sie_q, csr_sip_q, csr_stvec_q, csr_sepc_q
//   pipeline : pipe_flush, pipe_drained
//   commit   : trap_set, trap_is_irq, trap_scause, trap_sepc, trap_stval,
//              do_sret, next_priv
//   redirect : redirect_valid, redirect_pc, redirect_ready
interface trap_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic [1:0]      cur_priv;
    logic            exc_valid;
    logic [4:0]      exc_cause;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] exc_tval;
    logic            exc_ready;
    logic            sret_req;
    logic [XLEN-1:0] sret_pc;
    logic            sret_ready;
    logic [XLEN-1:0] irq_pc;
    logic [XLEN-1:0] csr_sstatus_q;
    logic [XLEN-1:0] csr_sie_q;
    logic [XLEN-1:0] csr_sip_q;
    logic [XLEN-1:0] csr_stvec_q;
    logic [XLEN-1:0] csr_sepc_q;
    logic            pipe_flush;
    logic            pipe_drained;
    logic            trap_set;
    logic            trap_is_irq;
    logic [XLEN-1:0] trap_scause;
    logic [XLEN-1:0] trap_sepc;
    logic [XLEN-1:0] trap_stval;
    logic            do_sret;
    logic [1:0]      next_priv;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (
        input  cur_priv, exc_valid, exc_cause, exc_pc, exc_tval,
        input  sret_req, sret_pc, irq_pc,
        input  csr_sstatus_q, csr_sie_q, csr_sip_q, csr_stvec_q, csr_sepc_q,
        input  pipe_drained, redirect_ready,
        output exc_ready, sret_ready, pipe_flush,
        output trap_set, trap_is_irq, trap_scause, trap_sepc, trap_stval,
        output do_sret, next_priv, redirect_valid, redirect_pc
    );

    modport slave (
        output cur_priv, exc_valid, exc_cause, exc_pc, exc_tval,
        output sret_req, sret_pc, irq_pc,
        output csr_sstatus_q, csr_sie_q, csr_sip_q, csr_stvec_q, csr_sepc_q,
        output pipe_drained, redirect_ready,
        input  exc_ready, sret_ready, pipe_flush,
        input  trap_set, trap_is_irq, trap_scause, trap_sepc, trap_stval,
        input  do_sret, next_priv, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_sequencer.sv
// Trap sequencer: picks one event per episode (exception > SRET > interrupt),
// drains the pipeline, commits exactly one trap or SRET to the CSR file, and
// then redirects fetch to the stvec / sepc target.
//
// Ports:
//   clk    - core clock
//   rst    - asynchronous active-high reset; aborts any episode in flight
//   bus_io - trap_sequencer_if.master (requests, CSR state, flush, commit, redirect)
//
// Configuration macro HARVOS_TRAP_IRQ_EN:
//   defined   - supervisor interrupts (SEI > SSI > STI) and vectored stvec targeting
//   undefined - only exceptions and SRET are sequenced; trap_is_irq tied to 0
module trap_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input logic              clk,
    input logic              rst,
    trap_sequencer_if.master bus_io
);

    typedef enum logic [1:0] {StIdle, StFlush, StCommit, StRedirect} state_e;

    localparam logic [1:0] PrivU = 2'd0;
    localparam logic [1:0] PrivS = 2'd1;
    localparam logic [1:0] PrivM = 2'd3;

    state_e          state_q;

    // Episode captured at acceptance.
    logic            ep_sret_q;
    logic            ep_irq_q;
    logic [XLEN-1:0] ep_scause_q;
    logic [XLEN-1:0] ep_sepc_q;
    logic [XLEN-1:0] ep_tval_q;
    logic [XLEN-1:0] ep_target_q;
    logic [1:0]      ep_priv_q;

    // Registered outputs.
    logic            pipe_flush_q;
    logic            trap_set_q;
    logic            trap_is_irq_q;
    logic [XLEN-1:0] trap_scause_q;
    logic [XLEN-1:0] trap_sepc_q;
    logic [XLEN-1:0] trap_stval_q;
    logic            do_sret_q;
    logic [1:0]      next_priv_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic [XLEN-1:0] irq_pend;
    logic            irq_take;
    logic [4:0]      irq_code;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] irq_target;

    assign tvec_base = bus_io.csr_stvec_q & ~XLEN'(3);

`ifdef HARVOS_TRAP_IRQ_EN
    assign irq_pend = bus_io.csr_sip_q & bus_io.csr_sie_q & XLEN'(32'h222);
    // M mode never takes supervisor interrupts; S mode needs sstatus.SIE.
    assign irq_take = (irq_pend != '0) &&
                      ((bus_io.cur_priv == PrivU) ||
                       ((bus_io.cur_priv == PrivS) && bus_io.csr_sstatus_q[1]));
    assign irq_target = (bus_io.csr_stvec_q[1:0] == 2'b01) ?
                        tvec_base + (XLEN'(irq_code) << 2) : tvec_base;
    assign bus_io.trap_is_irq = trap_is_irq_q;

    logic unused_sstatus;
    assign unused_sstatus = ^bus_io.csr_sstatus_q;
`else
    assign irq_pend   = '0;
    assign irq_take   = 1'b0;
    assign irq_target = tvec_base;
    assign bus_io.trap_is_irq = 1'b0;

    logic unused_irq;
    assign unused_irq = ^{bus_io.csr_sstatus_q, bus_io.csr_sie_q, bus_io.csr_sip_q,
                          trap_is_irq_q};
`endif

    always_comb begin
        if (irq_pend[9]) begin
            irq_code = 5'd9;
        end else if (irq_pend[1]) begin
            irq_code = 5'd1;
        end else begin
            irq_code = 5'd5;
        end
    end

    // Event decode; only meaningful in StIdle.
    logic            ev_valid;
    logic            ev_sret;
    logic            ev_irq;
    logic [XLEN-1:0] ev_scause;
    logic [XLEN-1:0] ev_sepc;
    logic [XLEN-1:0] ev_tval;
    logic [XLEN-1:0] ev_target;
    logic [1:0]      ev_priv;
    logic            exc_ready_c;
    logic            sret_ready_c;

    always_comb begin
        ev_valid     = 1'b0;
        ev_sret      = 1'b0;
        ev_irq       = 1'b0;
        ev_scause    = '0;
        ev_sepc      = '0;
        ev_tval      = '0;
        ev_target    = tvec_base;
        ev_priv      = PrivS;
        exc_ready_c  = 1'b0;
        sret_ready_c = 1'b0;
        if (state_q == StIdle) begin
            if (bus_io.exc_valid) begin
                exc_ready_c = 1'b1;
                ev_valid    = 1'b1;
                ev_scause   = XLEN'(bus_io.exc_cause);
                ev_sepc     = bus_io.exc_pc;
                ev_tval     = bus_io.exc_tval;
            end else if (bus_io.sret_req) begin
                sret_ready_c = 1'b1;
                ev_valid     = 1'b1;
                if (bus_io.cur_priv == PrivU) begin
                    // SRET is illegal from U mode: trap with cause 2.
                    ev_scause = XLEN'(5'd2);
                    ev_sepc   = bus_io.sret_pc;
                end else begin
                    ev_sret   = 1'b1;
                    ev_target = bus_io.csr_sepc_q;
                    ev_priv   = bus_io.csr_sstatus_q[8] ? PrivS : PrivU;
                end
            end else if (irq_take) begin
                ev_valid  = 1'b1;
                ev_irq    = 1'b1;
                ev_scause = {1'b1, {(XLEN - 6){1'b0}}, irq_code};
                ev_sepc   = bus_io.irq_pc;
                ev_target = irq_target;
            end
        end
    end

    assign bus_io.exc_ready  = exc_ready_c;
    assign bus_io.sret_ready = sret_ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            ep_sret_q        <= 1'b0;
            ep_irq_q         <= 1'b0;
            ep_scause_q      <= '0;
            ep_sepc_q        <= '0;
            ep_tval_q        <= '0;
            ep_target_q      <= '0;
            ep_priv_q        <= PrivM;
            pipe_flush_q     <= 1'b0;
            trap_set_q       <= 1'b0;
            trap_is_irq_q    <= 1'b0;
            trap_scause_q    <= '0;
            trap_sepc_q      <= '0;
            trap_stval_q     <= '0;
            do_sret_q        <= 1'b0;
            next_priv_q      <= PrivM;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            // Commit strobes are single-cycle by construction.
            trap_set_q <= 1'b0;
            do_sret_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ev_valid) begin
                        state_q      <= StFlush;
                        pipe_flush_q <= 1'b1;
                        ep_sret_q    <= ev_sret;
                        ep_irq_q     <= ev_irq;
                        ep_scause_q  <= ev_scause;
                        ep_sepc_q    <= ev_sepc;
                        ep_tval_q    <= ev_tval;
                        ep_target_q  <= ev_target;
                        ep_priv_q    <= ev_priv;
                    end
                end
                StFlush: begin
                    if (bus_io.pipe_drained) begin
                        state_q      <= StCommit;
                        pipe_flush_q <= 1'b0;
                        if (ep_sret_q) begin
                            do_sret_q <= 1'b1;
                        end else begin
                            trap_set_q    <= 1'b1;
                            trap_is_irq_q <= ep_irq_q;
                            trap_scause_q <= ep_scause_q;
                            trap_sepc_q   <= ep_sepc_q;
                            trap_stval_q  <= ep_tval_q;
                        end
                    end
                end
                StCommit: begin
                    state_q          <= StRedirect;
                    next_priv_q      <= ep_priv_q;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= ep_target_q;
                end
                StRedirect: begin
                    if (bus_io.redirect_ready) begin
                        state_q          <= StIdle;
                        redirect_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.pipe_flush     = pipe_flush_q;
    assign bus_io.trap_set       = trap_set_q;
    assign bus_io.trap_scause    = trap_scause_q;
    assign bus_io.trap_sepc      = trap_sepc_q;
    assign bus_io.trap_stval     = trap_stval_q;
    assign bus_io.do_sret        = do_sret_q;
    assign bus_io.next_priv      = next_priv_q;
    assign bus_io.redirect_valid = redirect_valid_q;
    assign bus_io.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: a vector table of single episodes,
// a commit scoreboard, and hand-written backpressure / reset sequences.
module tb_trap_sequencer;
    localparam int unsigned XLEN = 32;
`ifdef HARVOS_TRAP_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif
    localparam logic [1:0] KNone = 2'd0;
    localparam logic [1:0] KTrap = 2'd1;
    localparam logic [1:0] KSret = 2'd2;

    logic clk = 1'b0;
    logic rst;

    trap_sequencer_if #(.XLEN(XLEN)) bus ();

    trap_sequencer #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  priv;
        logic        exc;
        logic [4:0]  cause;
        logic [31:0] epc;
        logic [31:0] etval;
        logic        sret;
        logic [31:0] spc;
        logic [31:0] sstatus;
        logic [31:0] sie;
        logic [31:0] sip;
        logic [31:0] stvec;
        logic [31:0] sepc;
        logic [31:0] ipc;
        logic        irq_only;  // outcome applies only when interrupts are built in
        logic [1:0]  kind;
        logic        erdy;
        logic        srdy;
        logic        irq;
        logic [31:0] scause;
        logic [31:0] tsepc;
        logic [31:0] stval;
        logic [31:0] rpc;
        logic [1:0]  npriv;
    } vec_t;

    typedef struct {
        logic [1:0]  kind;
        logic        irq;
        logic [31:0] scause;
        logic [31:0] sepc;
        logic [31:0] stval;
        logic [31:0] rpc;
        logic [1:0]  npriv;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t rd_q[$];
    exp_t mon_e;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic vec_t mk(
        input string n, input logic [1:0] priv, input logic exc, input logic [4:0] cause,
        input logic [31:0] epc, input logic [31:0] etval, input logic sret,
        input logic [31:0] spc, input logic [31:0] sstatus, input logic [31:0] sie,
        input logic [31:0] sip, input logic [31:0] stvec, input logic [31:0] sepc,
        input logic [31:0] ipc, input logic irq_only, input logic [1:0] kind,
        input logic erdy, input logic srdy, input logic irq, input logic [31:0] scause,
        input logic [31:0] tsepc, input logic [31:0] stval, input logic [31:0] rpc,
        input logic [1:0] npriv);
        vec_t v;
        v.name = n; v.priv = priv; v.exc = exc; v.cause = cause; v.epc = epc;
        v.etval = etval; v.sret = sret; v.spc = spc; v.sstatus = sstatus; v.sie = sie;
        v.sip = sip; v.stvec = stvec; v.sepc = sepc; v.ipc = ipc; v.irq_only = irq_only;
        v.kind = kind; v.erdy = erdy; v.srdy = srdy; v.irq = irq; v.scause = scause;
        v.tsepc = tsepc; v.stval = stval; v.rpc = rpc; v.npriv = npriv;
        return v;
    endfunction

    task automatic clear_requests();
        bus.exc_valid = 1'b0;
        bus.exc_cause = '0;
        bus.exc_pc    = '0;
        bus.exc_tval  = '0;
        bus.sret_req  = 1'b0;
        bus.sret_pc   = '0;
        bus.csr_sip_q = '0;
        bus.irq_pc    = '0;
    endtask

    // Commit scoreboard: samples registered outputs 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (!rst && (bus.trap_set || bus.do_sret)) begin
            chk("strobe_exclusive", 32'(bus.trap_set & bus.do_sret), 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_commit trap_set=%0b do_sret=%0b required=none",
                         bus.trap_set, bus.do_sret);
            end else begin
                mon_e = sb_q.pop_front();
                chk("commit_kind", 32'(bus.trap_set ? KTrap : KSret), 32'(mon_e.kind));
                if (mon_e.kind == KTrap) begin
                    chk("trap_is_irq", 32'(bus.trap_is_irq), 32'(mon_e.irq));
                    chk("trap_scause", bus.trap_scause, mon_e.scause);
                    chk("trap_sepc", bus.trap_sepc, mon_e.sepc);
                    chk("trap_stval", bus.trap_stval, mon_e.stval);
                end
                rd_q.push_back(mon_e);
            end
        end
    end

    task automatic check_redirect(input string name);
        exp_t e;
        if (rd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s/redirect_no_commit actual=redirect required=commit_first", name);
        end else begin
            e = rd_q.pop_front();
            chk({name, "/redirect_pc"}, bus.redirect_pc, e.rpc);
            chk({name, "/next_priv"}, 32'(bus.next_priv), 32'(e.npriv));
        end
    endtask

    // Called in cycle 1 of an episode with pipe_drained=1 and redirect_ready=1.
    task automatic finish_episode(input string name);
        int commit_cyc = -1;
        int rd_cyc = -1;
        int strobes = 0;
        chk({name, "/flush"}, 32'(bus.pipe_flush), 32'd1);
        for (int c = 1; c <= 30 && rd_cyc < 0; c++) begin
            if (bus.trap_set || bus.do_sret) begin
                strobes++;
                commit_cyc = c;
            end
            if (bus.redirect_valid && bus.redirect_ready) begin
                rd_cyc = c;
                check_redirect(name);
            end
            tick();
        end
        chk({name, "/commit_cycle"}, 32'(commit_cyc), 32'd2);
        chk({name, "/redirect_cycle"}, 32'(rd_cyc), 32'd3);
        chk({name, "/strobes"}, 32'(strobes), 32'd1);
        chk({name, "/redirect_done"}, 32'(bus.redirect_valid), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        logic [1:0] kind;
        bus.cur_priv      = v.priv;
        bus.exc_valid     = v.exc;
        bus.exc_cause     = v.cause;
        bus.exc_pc        = v.epc;
        bus.exc_tval      = v.etval;
        bus.sret_req      = v.sret;
        bus.sret_pc       = v.spc;
        bus.csr_sstatus_q = v.sstatus;
        bus.csr_sie_q     = v.sie;
        bus.csr_sip_q     = v.sip;
        bus.csr_stvec_q   = v.stvec;
        bus.csr_sepc_q    = v.sepc;
        bus.irq_pc        = v.ipc;
        bus.pipe_drained  = 1'b1;
        bus.redirect_ready = 1'b1;
        #1;
        chk({v.name, "/exc_ready"}, 32'(bus.exc_ready), 32'(v.erdy));
        chk({v.name, "/sret_ready"}, 32'(bus.sret_ready), 32'(v.srdy));
        kind = (v.irq_only && !IrqEn) ? KNone : v.kind;
        if (kind != KNone) begin
            e.kind = kind; e.irq = v.irq; e.scause = v.scause; e.sepc = v.tsepc;
            e.stval = v.stval; e.rpc = v.rpc; e.npriv = v.npriv;
            sb_q.push_back(e);
        end
        tick();
        if (kind == KNone) begin
            repeat (3) begin
                chk({v.name, "/no_flush"}, 32'(bus.pipe_flush), 32'd0);
                tick();
            end
            clear_requests();
            tick();
        end else begin
            clear_requests();
            finish_episode(v.name);
        end
    endtask

    initial begin
        // Table: name priv exc cause epc etval sret spc sstatus sie sip stvec sepc ipc
        //        irq_only kind erdy srdy irq scause tsepc stval rpc npriv
        vecs.push_back(mk("exc", 2'd0, 1, 5'd13, 32'h1000, 32'hDEAD, 0, 0, 0, 0, 0,
            32'h8000_0101, 0, 0, 0, KTrap, 1, 0, 0, 32'd13, 32'h1000, 32'hDEAD,
            32'h8000_0100, 2'd1));
        vecs.push_back(mk("irq_vec", 2'd1, 0, 0, 0, 0, 0, 0, 32'h2, 32'h222, 32'h222,
            32'h401, 0, 32'h2000, 1, KTrap, 0, 0, 1, 32'h8000_0009, 32'h2000, 0,
            32'h424, 2'd1));
        vecs.push_back(mk("sret_s", 2'd1, 0, 0, 0, 0, 1, 32'h50, 0, 0, 0, 32'h100,
            32'h3000, 0, 0, KSret, 0, 1, 0, 0, 0, 0, 32'h3000, 2'd0));
        vecs.push_back(mk("sret_u", 2'd0, 0, 0, 0, 0, 1, 32'h44, 32'h100, 0, 0,
            32'h8000_0101, 32'h9999, 0, 0, KTrap, 0, 1, 0, 32'd2, 32'h44, 0,
            32'h8000_0100, 2'd1));
        vecs.push_back(mk("sret_m_spp", 2'd3, 0, 0, 0, 0, 1, 32'h58, 32'h100, 0, 0,
            32'h100, 32'h4000, 0, 0, KSret, 0, 1, 0, 0, 0, 0, 32'h4000, 2'd1));
        vecs.push_back(mk("irq_m", 2'd3, 0, 0, 0, 0, 0, 0, 32'h2, 32'h222, 32'h222,
            32'h401, 0, 32'h2000, 0, KNone, 0, 0, 0, 0, 0, 0, 0, 2'd0));
        vecs.push_back(mk("irq_s_off", 2'd1, 0, 0, 0, 0, 0, 0, 0, 32'h222, 32'h222,
            32'h401, 0, 32'h2000, 0, KNone, 0, 0, 0, 0, 0, 0, 0, 2'd0));
        vecs.push_back(mk("irq_sti", 2'd0, 0, 0, 0, 0, 0, 0, 0, 32'h222, 32'h020,
            32'h601, 0, 32'h2222, 1, KTrap, 0, 0, 1, 32'h8000_0005, 32'h2222, 0,
            32'h614, 2'd1));
        vecs.push_back(mk("irq_ssi", 2'd0, 0, 0, 0, 0, 0, 0, 0, 32'h002, 32'h022,
            32'h600, 0, 32'h3330, 1, KTrap, 0, 0, 1, 32'h8000_0001, 32'h3330, 0,
            32'h600, 2'd1));
        vecs.push_back(mk("exc_over_irq", 2'd1, 1, 5'd5, 32'h7000, 32'h70, 0, 0, 32'h2,
            32'h200, 32'h200, 32'h203, 0, 32'h10, 0, KTrap, 1, 0, 0, 32'd5, 32'h7000,
            32'h70, 32'h200, 2'd1));
        vecs.push_back(mk("irq_wrap", 2'd1, 0, 0, 0, 0, 0, 0, 32'h2, 32'h200, 32'h200,
            32'hFFFF_FFFD, 0, 32'h10, 1, KTrap, 0, 0, 1, 32'h8000_0009, 32'h10, 0,
            32'h20, 2'd1));
        vecs.push_back(mk("irq_masked", 2'd0, 0, 0, 0, 0, 0, 0, 0, 32'hFFF, 32'h888,
            32'h401, 0, 32'h10, 0, KNone, 0, 0, 0, 0, 0, 0, 0, 2'd0));

        rst = 1'b1;
        clear_requests();
        bus.cur_priv       = 2'd0;
        bus.csr_sstatus_q  = '0;
        bus.csr_sie_q      = '0;
        bus.csr_stvec_q    = '0;
        bus.csr_sepc_q     = '0;
        bus.pipe_drained   = 1'b1;
        bus.redirect_ready = 1'b1;
        tick();
        tick();
        chk("reset/ctl", {25'd0, bus.pipe_flush, bus.trap_set, bus.do_sret, bus.trap_is_irq,
            bus.redirect_valid, bus.next_priv}, 32'h3);
        chk("reset/data", bus.trap_scause | bus.trap_sepc | bus.trap_stval | bus.redirect_pc,
            32'h0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Simultaneous exception, SRET and interrupt with drain backpressure.
        begin
            exp_t e;
            int commit_cyc = -1;
            int rv_cnt = 0;
            logic [31:0] pc0 = '0;
            bus.cur_priv = 2'd1; bus.csr_sstatus_q = 32'h2;
            bus.csr_sie_q = 32'h200; bus.csr_sip_q = 32'h200; bus.irq_pc = 32'h88;
            bus.exc_valid = 1'b1; bus.exc_cause = 5'd7; bus.exc_pc = 32'h5000;
            bus.exc_tval = 32'h77; bus.sret_req = 1'b1; bus.sret_pc = 32'h60;
            bus.csr_stvec_q = 32'h100; bus.csr_sepc_q = 32'h6000;
            bus.pipe_drained = 1'b0; bus.redirect_ready = 1'b0;
            #1;
            chk("simul/exc_ready", 32'(bus.exc_ready), 32'd1);
            chk("simul/sret_ready", 32'(bus.sret_ready), 32'd0);
            e.kind = KTrap; e.irq = 1'b0; e.scause = 32'd7; e.sepc = 32'h5000;
            e.stval = 32'h77; e.rpc = 32'h100; e.npriv = 2'd1;
            sb_q.push_back(e);
            tick();
            bus.exc_valid = 1'b0; bus.exc_cause = '0; bus.exc_pc = '0; bus.exc_tval = '0;
            #1;
            for (int c = 1; c <= 5; c++) begin
                chk("simul/flush_hold", 32'(bus.pipe_flush), 32'd1);
                chk("simul/sret_blocked", 32'(bus.sret_ready), 32'd0);
                tick();
            end
            bus.pipe_drained = 1'b1;
            for (int c = 6; c <= 40 && rv_cnt < 3; c++) begin
                if (bus.trap_set) commit_cyc = c;
                if (bus.redirect_valid) begin
                    rv_cnt++;
                    if (rv_cnt == 1) pc0 = bus.redirect_pc;
                    else chk("simul/redirect_stable", bus.redirect_pc, pc0);
                    if (rv_cnt == 3) begin
                        check_redirect("simul");
                        bus.redirect_ready = 1'b1;
                    end
                end
                tick();
            end
            chk("simul/commit_cycle", 32'(commit_cyc), 32'd7);
            chk("simul/redirect_seen", 32'(rv_cnt), 32'd3);
            chk("simul/idle", 32'(bus.redirect_valid), 32'd0);
            chk("simul/sret_next", 32'(bus.sret_ready), 32'd1);
            chk("simul/exc_quiet", 32'(bus.exc_ready), 32'd0);
            e.kind = KSret; e.irq = 1'b0; e.scause = '0; e.sepc = '0; e.stval = '0;
            e.rpc = 32'h6000; e.npriv = 2'd0;
            sb_q.push_back(e);
            tick();
            clear_requests();
            finish_episode("simul_sret");
        end

        // Reset while flushing: the episode must vanish without a commit.
        bus.cur_priv = 2'd0; bus.csr_stvec_q = 32'h100;
        bus.exc_valid = 1'b1; bus.exc_cause = 5'd4; bus.exc_pc = 32'h900;
        bus.exc_tval = 32'h9; bus.pipe_drained = 1'b0; bus.redirect_ready = 1'b1;
        #1;
        chk("rst_mid/exc_ready", 32'(bus.exc_ready), 32'd1);
        tick();
        clear_requests();
        chk("rst_mid/flush", 32'(bus.pipe_flush), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid/ctl", {25'd0, bus.pipe_flush, bus.trap_set, bus.do_sret,
            bus.trap_is_irq, bus.redirect_valid, bus.next_priv}, 32'h3);
        chk("rst_mid/data", bus.trap_scause | bus.trap_sepc | bus.trap_stval |
            bus.redirect_pc, 32'h0);
        tick();
        bus.pipe_drained = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) begin
            tick();
            chk("rst_mid/quiet", {30'd0, bus.pipe_flush, bus.redirect_valid}, 32'd0);
        end

        chk("scoreboard_empty", 32'(sb_q.size() + rd_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
